// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_ctrl_pkg
// Brief  : Op codes, load-size codes and state encoding shared by the
//          load/store sequencer and the control unit.
// Rev    : 1.0
// ============================================================================
package mem_ctrl_pkg;

    localparam logic [2:0] c_OP_LW = 3'b000;
    localparam logic [2:0] c_OP_LH = 3'b001;
    localparam logic [2:0] c_OP_LB = 3'b010;
    localparam logic [2:0] c_OP_SW = 3'b100;
    localparam logic [2:0] c_OP_SH = 3'b101;
    localparam logic [2:0] c_OP_SB = 3'b110;

    localparam logic [1:0] c_LSZ_WORD = 2'b00;
    localparam logic [1:0] c_LSZ_HALF = 2'b01;
    localparam logic [1:0] c_LSZ_BYTE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == c_OP_LW) || (op == c_OP_LH) || (op == c_OP_LB) ||
               (op == c_OP_SW) || (op == c_OP_SH) || (op == c_OP_SB);
    endfunction

    function automatic logic op_is_load(input logic [2:0] op);
        return op_is_legal(op) && !op[2];
    endfunction

    function automatic logic addr_aligned(input logic [2:0] op, input logic [1:0] lsb);
        logic ok;
        case (op)
            c_OP_LW, c_OP_SW: ok = (lsb == 2'b00);
            c_OP_LH, c_OP_SH: ok = !lsb[0];
            default:          ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] load_size(input logic [2:0] op);
        logic [1:0] sz;
        case (op)
            c_OP_LH: sz = c_LSZ_HALF;
            c_OP_LB: sz = c_LSZ_BYTE;
            default: sz = c_LSZ_WORD;
        endcase
        return sz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_merge.sv
`default_nettype none
// ============================================================================
// Module : store_merge
// Brief  : Merges store data into the memory word for sub-word stores.
// Rev    : 1.0
// ============================================================================
module store_merge (
    input  logic [2:0]  op,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] wdata,
    output logic [31:0] merged
);
    import mem_ctrl_pkg::*;

    logic [31:0] w_mask;

    // Mask selects the bytes taken from the store data; the rest come from memory.
    always_comb begin
        case (op)
            c_OP_SH: w_mask = 32'h0000_FFFF;
            c_OP_SB: w_mask = 32'h0000_00FF;
            default: w_mask = 32'hFFFF_FFFF;
        endcase
    end

    assign merged = (mem_rdata & ~w_mask) | (wdata & w_mask);

endmodule
`default_nettype wire

// File: rtl/load_store_sequencer.sv
`default_nettype none
// ============================================================================
// Module : load_store_sequencer
// Brief  : Sequences word/half/byte loads and stores, with read-merge-write
//          for sub-word stores and alignment/illegal-op fault reporting.
// Rev    : 1.0
// ============================================================================
module load_store_sequencer #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  load_size_ctrl,
    output logic        mdr_load_en,
    output logic        busy,
    output logic        done,
    output logic        error
);
    import mem_ctrl_pkg::*;

    localparam logic [1:0] c_LAST_CNT = 2'(MEM_LATENCY - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merged_q, merged_d;

    logic [31:0] w_merged;
    logic        w_read_last;
    logic        w_is_load;

    store_merge u_store_merge (
        .op        (op_q),
        .mem_rdata (mem_rdata),
        .wdata     (wdata_q),
        .merged    (w_merged)
    );

    assign w_read_last = (cnt_q == c_LAST_CNT);
    assign w_is_load   = op_is_load(op_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merged_q <= merged_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merged_d = merged_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    op_d    = op;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = '0;
                    if (!op_is_legal(op) || !addr_aligned(op, addr[1:0])) begin
                        state_d = ST_ERR;
                    end else if (op == c_OP_SW) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (w_read_last) begin
                    if (w_is_load) begin
                        state_d = ST_DONE;
                    end else begin
                        merged_d = w_merged;
                        state_d  = ST_WRITE;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign error          = (state_q == ST_ERR);
    assign mem_addr       = addr_q;
    assign mem_wr         = (state_q == ST_WRITE);
    // sw writes the raw store data; sub-word stores write the word merged in READ.
    assign mem_wdata      = mem_wr ? ((op_q == c_OP_SW) ? wdata_q : merged_q) : '0;
    assign mdr_load_en    = (state_q == ST_READ) && w_read_last && w_is_load;
    assign load_size_ctrl = (busy && w_is_load) ? load_size(op_q) : c_LSZ_WORD;

endmodule
`default_nettype wire

// File: tb/tb_load_store_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_load_store_sequencer
// Brief  : Self-checking bench; four sequencers, one per legal memory latency.
// Rev    : 1.0
// ============================================================================
module tb_load_store_sequencer;

    logic        clk = 1'b0;
    logic        rst_a   [4];
    logic        req_a   [4];
    logic [2:0]  op_a    [4];
    logic [31:0] addr_a  [4];
    logic [31:0] wdata_a [4];
    logic [31:0] rdata_a [4];
    logic [31:0] maddr_a [4];
    logic [31:0] mwd_a   [4];
    logic        mwr_a   [4];
    logic [1:0]  lsz_a   [4];
    logic        mdr_a   [4];
    logic        busy_a  [4];
    logic        done_a  [4];
    logic        err_a   [4];

    int n_checks = 0;
    int n_errors = 0;

    // Observations of the last transaction, cycle index relative to acceptance.
    int          o_done_cyc, o_done_cnt, o_err_cnt, o_mdr_cyc, o_mdr_cnt;
    int          o_wr_cyc, o_wr_cnt, o_leak, o_addr_bad;
    logic [31:0] o_wr_addr, o_wr_data;
    logic [10:0] o_busy_v;
    logic [21:0] o_lsz_v;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        load_store_sequencer #(.MEM_LATENCY(g + 1)) u_dut (
            .clk            (clk),
            .reset          (rst_a[g]),
            .req            (req_a[g]),
            .op             (op_a[g]),
            .addr           (addr_a[g]),
            .wdata          (wdata_a[g]),
            .mem_rdata      (rdata_a[g]),
            .mem_addr       (maddr_a[g]),
            .mem_wr         (mwr_a[g]),
            .mem_wdata      (mwd_a[g]),
            .load_size_ctrl (lsz_a[g]),
            .mdr_load_en    (mdr_a[g]),
            .busy           (busy_a[g]),
            .done           (done_a[g]),
            .error          (err_a[g])
        );
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    // Issue one request on instance k and record what happens for 10 cycles.
    task automatic run_txn(input int k, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] mw);
        @(negedge clk);
        op_a[k] = o; addr_a[k] = a; wdata_a[k] = wd; rdata_a[k] = mw; req_a[k] = 1'b1;
        @(negedge clk);
        req_a[k] = 1'b0; op_a[k] = 3'($urandom); addr_a[k] = $urandom; wdata_a[k] = $urandom;
        o_done_cyc = 0; o_done_cnt = 0; o_err_cnt = 0; o_mdr_cyc = 0; o_mdr_cnt = 0;
        o_wr_cyc = 0; o_wr_cnt = 0; o_leak = 0; o_addr_bad = 0;
        o_wr_addr = '0; o_wr_data = '0; o_busy_v = '0; o_lsz_v = '0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk);
            if (done_a[k]) begin
                o_done_cnt++;
                if (o_done_cyc == 0) o_done_cyc = c;
            end
            if (err_a[k]) o_err_cnt++;
            if (mdr_a[k]) begin o_mdr_cnt++; o_mdr_cyc = c; end
            if (mwr_a[k]) begin
                o_wr_cnt++; o_wr_cyc = c; o_wr_addr = maddr_a[k]; o_wr_data = mwd_a[k];
            end else if (mwd_a[k] !== 32'h0) begin
                o_leak++;
            end
            if (maddr_a[k] !== a) o_addr_bad++;
            o_busy_v[c] = busy_a[k];
            o_lsz_v[2*c +: 2] = lsz_a[k];
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin rst_a[k] = 1'b1; req_a[k] = 1'b0; end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({busy_a[k], done_a[k], err_a[k], mwr_a[k], mdr_a[k], lsz_a[k], maddr_a[k], mwd_a[k]} !== 71'h0) begin
                n_errors++;
                $display("FAIL reset_outputs[%0d]: got busy=%b done=%b err=%b wr=%b mdr=%b lsz=%b addr=%h wd=%h want all 0",
                         k, busy_a[k], done_a[k], err_a[k], mwr_a[k], mdr_a[k], lsz_a[k], maddr_a[k], mwd_a[k]);
            end
        end
        for (int k = 0; k < 4; k++) rst_a[k] = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({busy_a[k], done_a[k], mwr_a[k], maddr_a[k]} !== 35'h0) begin
                n_errors++;
                $display("FAIL post_reset_idle[%0d]: got busy=%b done=%b wr=%b addr=%h want 0", k,
                         busy_a[k], done_a[k], mwr_a[k], maddr_a[k]);
            end
        end
    endtask

    task automatic test_load_byte();
        run_txn(0, 3'b010, 32'h0000_0013, 32'h5555_5555, 32'hAABB_CCDD);
        n_checks++;
        if (o_mdr_cyc !== 1 || o_mdr_cnt !== 1) begin
            n_errors++; $display("FAIL lb_mdr: got cyc=%0d cnt=%0d want cyc=1 cnt=1", o_mdr_cyc, o_mdr_cnt);
        end
        n_checks++;
        if (o_lsz_v[3:2] !== 2'b10) begin
            n_errors++; $display("FAIL lb_lsz: got %b want 10", o_lsz_v[3:2]);
        end
        n_checks++;
        if (o_done_cyc !== 2 || o_err_cnt !== 0) begin
            n_errors++; $display("FAIL lb_done: got cyc=%0d err=%0d want cyc=2 err=0", o_done_cyc, o_err_cnt);
        end
        n_checks++;
        if (o_wr_cnt !== 0) begin
            n_errors++; $display("FAIL lb_no_write: got %0d writes want 0", o_wr_cnt);
        end
    endtask

    task automatic test_store_byte();
        run_txn(0, 3'b110, 32'h0000_0020, 32'h1234_5678, 32'hCAFE_BABE);
        n_checks++;
        if (o_wr_cnt !== 1 || o_wr_cyc !== 2) begin
            n_errors++; $display("FAIL sb_write_timing: got cnt=%0d cyc=%0d want cnt=1 cyc=2", o_wr_cnt, o_wr_cyc);
        end
        n_checks++;
        if (o_wr_data !== 32'hCAFE_BA78 || o_wr_addr !== 32'h0000_0020) begin
            n_errors++; $display("FAIL sb_write_data: got %h@%h want cafeba78@00000020", o_wr_data, o_wr_addr);
        end
        n_checks++;
        if (o_done_cyc !== 3 || o_lsz_v !== 22'h0) begin
            n_errors++; $display("FAIL sb_done_lsz: got done=%0d lsz=%h want done=3 lsz=0", o_done_cyc, o_lsz_v);
        end
    endtask

    task automatic test_misaligned();
        run_txn(0, 3'b000, 32'h0000_0006, 32'h0, 32'h1111_2222);
        n_checks++;
        if (o_done_cyc !== 1 || o_err_cnt !== 1 || o_done_cnt !== 1) begin
            n_errors++; $display("FAIL misaligned_err: got done=%0d err=%0d ndone=%0d want 1 1 1",
                                 o_done_cyc, o_err_cnt, o_done_cnt);
        end
        n_checks++;
        if (o_wr_cnt !== 0 || o_mdr_cnt !== 0 || o_busy_v[2] !== 1'b0) begin
            n_errors++; $display("FAIL misaligned_side: got wr=%0d mdr=%0d busy2=%b want 0 0 0",
                                 o_wr_cnt, o_mdr_cnt, o_busy_v[2]);
        end
    endtask

    task automatic test_illegal();
        logic [10:0] dv, wv;
        run_txn(0, 3'b011, 32'h0000_0100, 32'h0, 32'h0);
        n_checks++;
        if (o_err_cnt !== 1 || o_done_cyc !== 1 || o_wr_cnt !== 0 || o_mdr_cnt !== 0 || o_lsz_v !== 22'h0) begin
            n_errors++; $display("FAIL illegal_op: got err=%0d done=%0d wr=%0d mdr=%0d lsz=%h want 1 1 0 0 0",
                                 o_err_cnt, o_done_cyc, o_wr_cnt, o_mdr_cnt, o_lsz_v);
        end
        // A store request raised mid-load must be dropped, not queued.
        dv = '0; wv = '0;
        @(negedge clk);
        op_a[3] = 3'b000; addr_a[3] = 32'h0000_0040; rdata_a[3] = 32'h0BAD_F00D; req_a[3] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) req_a[3] = 1'b0;
            dv[c] = done_a[3]; wv[c] = mwr_a[3];
            if (c == 2) begin req_a[3] = 1'b1; op_a[3] = 3'b100; addr_a[3] = 32'h0000_0080; end
            if (c == 3) req_a[3] = 1'b0;
        end
        n_checks++;
        if (dv !== (11'd1 << 5) || wv !== 11'd0) begin
            n_errors++; $display("FAIL busy_req_ignored: got done=%b wr=%b want done=%b wr=0", dv, wv, 11'd1 << 5);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] dv, wv, bv, mv;
        logic [21:0] lv;
        logic [31:0] wa, wd;
        dv = '0; wv = '0; bv = '0; mv = '0; lv = '0; wa = '0; wd = '0;
        @(negedge clk);
        op_a[2] = 3'b001; addr_a[2] = 32'h0000_0010; rdata_a[2] = 32'h7777_8888; req_a[2] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin op_a[2] = 3'b100; addr_a[2] = 32'h0000_0014; wdata_a[2] = 32'hFEED_5EED; end
            dv[c] = done_a[2]; wv[c] = mwr_a[2]; bv[c] = busy_a[2]; mv[c] = mdr_a[2];
            lv[2*c +: 2] = lsz_a[2];
            if (mwr_a[2]) begin wa = maddr_a[2]; wd = mwd_a[2]; end
            if (c == 6) req_a[2] = 1'b0;
        end
        n_checks++;
        if (dv !== ((11'd1 << 4) | (11'd1 << 7))) begin
            n_errors++; $display("FAIL b2b_done: got %b want done at cycles 4 and 7", dv);
        end
        n_checks++;
        if (wv !== (11'd1 << 6) || wa !== 32'h0000_0014 || wd !== 32'hFEED_5EED) begin
            n_errors++; $display("FAIL b2b_write: got wr=%b %h@%h want cycle 6 feed5eed@00000014", wv, wd, wa);
        end
        n_checks++;
        if (bv !== 11'b000_1101_1110 || mv !== (11'd1 << 3)) begin
            n_errors++; $display("FAIL b2b_busy_mdr: got busy=%b mdr=%b want 00011011110 00000001000", bv, mv);
        end
        n_checks++;
        if (lv !== 22'b00_0000_0000_0001_0101_0100) begin
            n_errors++; $display("FAIL b2b_lsz: got %b want half for cycles 1-4 only", lv);
        end
    endtask

    task automatic test_reset_mid();
        int nd, nw;
        nd = 0; nw = 0;
        @(negedge clk);
        op_a[1] = 3'b101; addr_a[1] = 32'h0000_0020; wdata_a[1] = 32'hAAAA_BBBB;
        rdata_a[1] = 32'h1234_5678; req_a[1] = 1'b1;
        @(negedge clk);
        req_a[1] = 1'b0;
        @(negedge clk);
        rst_a[1] = 1'b1;
        @(negedge clk);
        rst_a[1] = 1'b0;
        n_checks++;
        if ({busy_a[1], done_a[1], err_a[1], mwr_a[1], mdr_a[1], lsz_a[1], maddr_a[1], mwd_a[1]} !== 71'h0) begin
            n_errors++; $display("FAIL reset_mid_outputs: got busy=%b done=%b wr=%b addr=%h wd=%h want all 0",
                                 busy_a[1], done_a[1], mwr_a[1], maddr_a[1], mwd_a[1]);
        end
        for (int c = 0; c < 8; c++) begin
            if (done_a[1]) nd++;
            if (mwr_a[1]) nw++;
            @(negedge clk);
        end
        n_checks++;
        if (nd !== 0 || nw !== 0) begin
            n_errors++; $display("FAIL reset_mid_abort: got done=%0d writes=%0d want 0 0", nd, nw);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 48; t++) begin
            int k, lat, e_done, e_err, e_mdr_cyc, e_wr_cyc;
            logic [2:0] o;
            logic [31:0] a, wd, mw, e_wr_data, e_wr_addr;
            logic legal, aligned;
            logic [1:0] e_lsz;
            logic [10:0] e_busy;
            logic [21:0] e_lszv, lmask;
            k = $urandom_range(0, 3); lat = k + 1;
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            wd = $urandom; mw = $urandom;
            legal = (o != 3'b011) && (o != 3'b111);
            case (o)
                3'b000, 3'b100: aligned = (a % 4) == 0;
                3'b001, 3'b101: aligned = (a % 2) == 0;
                default:        aligned = 1'b1;
            endcase
            e_err = 0; e_mdr_cyc = 0; e_wr_cyc = 0; e_wr_data = '0; e_wr_addr = '0; e_lsz = 2'b00;
            if (!legal || !aligned) begin
                e_done = 1; e_err = 1;
            end else if (o[2] == 1'b0) begin
                e_done = lat + 1; e_mdr_cyc = lat;
                e_lsz = (o == 3'b001) ? 2'b01 : (o == 3'b010) ? 2'b10 : 2'b00;
            end else if (o == 3'b100) begin
                e_done = 2; e_wr_cyc = 1; e_wr_data = wd; e_wr_addr = a;
            end else begin
                e_done = lat + 2; e_wr_cyc = lat + 1; e_wr_addr = a;
                e_wr_data = (o == 3'b101) ? {mw[31:16], wd[15:0]} : {mw[31:8], wd[7:0]};
            end
            e_busy = '0; e_lszv = '0; lmask = '1;
            for (int c = 1; c <= 10; c++) begin
                if (c <= e_done) begin
                    e_busy[c] = 1'b1;
                    e_lszv[2*c +: 2] = e_lsz;
                    if (e_err == 1) lmask[2*c +: 2] = 2'b00;
                end
            end
            run_txn(k, o, a, wd, mw);
            n_checks++;
            if (o_done_cyc !== e_done || o_done_cnt !== 1) begin
                n_errors++; $display("FAIL rnd%0d_done: lat=%0d op=%b addr=%h got cyc=%0d cnt=%0d want cyc=%0d cnt=1",
                                     t, lat, o, a, o_done_cyc, o_done_cnt, e_done);
            end
            n_checks++;
            if (o_err_cnt !== e_err) begin
                n_errors++; $display("FAIL rnd%0d_error: op=%b addr=%h got %0d want %0d", t, o, a, o_err_cnt, e_err);
            end
            n_checks++;
            if (o_mdr_cyc !== e_mdr_cyc || o_mdr_cnt !== ((e_mdr_cyc != 0) ? 1 : 0)) begin
                n_errors++; $display("FAIL rnd%0d_mdr: lat=%0d op=%b got cyc=%0d cnt=%0d want cyc=%0d",
                                     t, lat, o, o_mdr_cyc, o_mdr_cnt, e_mdr_cyc);
            end
            n_checks++;
            if (o_wr_cyc !== e_wr_cyc || o_wr_cnt !== ((e_wr_cyc != 0) ? 1 : 0)) begin
                n_errors++; $display("FAIL rnd%0d_wr_timing: lat=%0d op=%b got cyc=%0d cnt=%0d want cyc=%0d",
                                     t, lat, o, o_wr_cyc, o_wr_cnt, e_wr_cyc);
            end
            n_checks++;
            if (o_wr_data !== e_wr_data || o_wr_addr !== e_wr_addr) begin
                n_errors++; $display("FAIL rnd%0d_wr_data: op=%b got %h@%h want %h@%h",
                                     t, o, o_wr_data, o_wr_addr, e_wr_data, e_wr_addr);
            end
            n_checks++;
            if (o_busy_v !== e_busy) begin
                n_errors++; $display("FAIL rnd%0d_busy: lat=%0d op=%b got %b want %b", t, lat, o, o_busy_v, e_busy);
            end
            n_checks++;
            if ((o_lsz_v & lmask) !== e_lszv) begin
                n_errors++; $display("FAIL rnd%0d_lsz: op=%b got %h want %h", t, o, o_lsz_v & lmask, e_lszv);
            end
            n_checks++;
            if (o_leak !== 0 || o_addr_bad !== 0) begin
                n_errors++; $display("FAIL rnd%0d_addr_wdata: got wdata_leak=%0d addr_bad=%0d want 0 0",
                                     t, o_leak, o_addr_bad);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            rst_a[k] = 1'b1; req_a[k] = 1'b0; op_a[k] = '0;
            addr_a[k] = '0; wdata_a[k] = '0; rdata_a[k] = '0;
        end
        test_reset();
        test_load_byte();
        test_store_byte();
        test_misaligned();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_sequencer.md
LOAD_STORE_SEQUENCER -- requirements
Module: load_store_sequencer

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1, legal 1..4: cycles from mem_addr valid to mem_rdata valid.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  1  access request, sampled only in IDLE.
REQ-005 SHALL have port op  input  3  access type: 000 lw, 001 lh, 010 lb, 100 sw, 101 sh, 110 sb; all other codes illegal.
REQ-006 SHALL have port addr  input  32  byte address of the access.
REQ-007 SHALL have port wdata  input  32  store source data.
REQ-008 SHALL have port mem_rdata  input  32  memory read data, holding the word that starts at mem_addr.
REQ-009 SHALL have port mem_addr  output  32  memory address.
REQ-010 SHALL have port mem_wr  output  1  memory write strobe.
REQ-011 SHALL have port mem_wdata  output  32  memory write data.
REQ-012 SHALL have port load_size_ctrl  output  2  control for the load-size extension unit: 00 word, 01 half zero-extend, 10 byte zero-extend.
REQ-013 SHALL have port mdr_load_en  output  1  one-cycle enable for capturing the extended load result.
REQ-014 SHALL have ports busy, done, error  output  1 each: access in progress; completion pulse; fault pulse.

Function
REQ-015 SHALL implement the states IDLE, READ, WRITE, DONE and ERR.
REQ-016 In IDLE with req=1, SHALL latch op, addr and wdata at the edge (acceptance cycle N).
REQ-017 Acceptance with a legal and aligned access SHALL go to READ for loads, sh and sb, and to WRITE for sw.
REQ-018 SHALL check alignment as follows: lw and sw need addr[1:0]=00; lh and sh need addr[0]=0; lb and sb need no alignment.
REQ-019 Acceptance with an illegal op or a misaligned address SHALL go to ERR, with no memory access (mem_wr stays 0).
REQ-020 READ SHALL last exactly MEM_LATENCY cycles, counted by an internal counter, with mem_addr equal to the latched addr and mem_wr=0.
REQ-021 On the last READ cycle of a load, SHALL assert mdr_load_en=1 for one cycle and then go to DONE; done therefore occurs in cycle N+MEM_LATENCY+1.
REQ-022 On the last READ cycle of sh or sb, SHALL register the merged word and go to WRITE.
REQ-023 For sh the merged word SHALL be {mem_rdata[31:16], wdata[15:0]}; for sb it SHALL be {mem_rdata[31:8], wdata[7:0]}.
REQ-024 WRITE SHALL assert mem_wr=1 for exactly one cycle, with mem_addr equal to the latched addr and mem_wdata equal to wdata (sw) or the merged word (sh/sb), and SHALL then go to DONE.
REQ-025 Completion timing SHALL be: sw done in cycle N+2; sh/sb done in cycle N+MEM_LATENCY+2.
REQ-026 DONE SHALL assert done=1 for one cycle and then return to IDLE.
REQ-027 ERR SHALL assert done=1 and error=1 for one cycle and then return to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 req SHALL be ignored while busy=1, and requests SHALL NOT be queued.
REQ-030 A req held high in the cycle after done SHALL start a new access; requesters drop req in the done cycle.
REQ-031 load_size_ctrl SHALL be 00 for lw, 01 for lh and 10 for lb, valid from cycle N+1 until the return to IDLE.
REQ-032 load_size_ctrl SHALL be 00 in IDLE and during store accesses.
REQ-033 mem_wdata SHALL be 0 outside WRITE; mem_addr SHALL hold its last value in IDLE.

Reset
REQ-034 reset=1 SHALL force IDLE and clear the counter and all latches.
REQ-035 During and after reset SHALL drive: busy, done, error, mem_wr, mdr_load_en = 0; mem_addr, mem_wdata = 0; load_size_ctrl = 00.
REQ-036 Reset mid-access SHALL abort the access without a done pulse.
REQ-037 A write presented in the same cycle as reset MAY complete; no write SHALL occur after that cycle.
REQ-038 reset SHALL have priority over req in the same cycle.

Structure
REQ-039 Op encodings, load-size codes and the state encoding SHALL live in the shared package mem_ctrl_pkg, also used by the control unit.
REQ-040 The combinational sh/sb merge SHALL be the sub-module store_merge (inputs op, mem_rdata, wdata; output 32-bit merged word).
REQ-041 The block SHALL contain no datapath extension logic; extension remains in the existing load-size unit.

Verification
REQ-042 Load byte: MEM_LATENCY=1, lb at addr 0x00000013, mem_rdata=0xAABBCCDD -> load_size_ctrl=10 and mdr_load_en in N+1, done in N+2, mem_wr never 1.
REQ-043 Store byte: sb at addr 0x20, wdata=0x12345678, memory word 0xCAFEBABE -> single write 0xCAFEBA78 at 0x20 in N+2, done in N+3.
REQ-044 Misaligned word: lw at addr 0x00000006 -> error=1 and done=1 in N+1, no mem_wr, busy=0 in N+2.
REQ-045 Latency and back-to-back: MEM_LATENCY=3, lh at 0x10 followed immediately by sw at 0x14 with req held -> lh done at N+4, sw accepted at N+5, write at N+6.
REQ-046 Reset mid-access: reset in the second READ cycle of an sh with MEM_LATENCY=2 -> next cycle IDLE, all outputs at reset values, no done, no write.
REQ-047 Illegal op: op=011 -> error pulse only; a req that arrives while busy is not accepted.
